mult_pipeline_b: RTL and testbench
==================================

# mult_pipeline_b

Second-generation pipelined shift-add multiplier for the arithmetic datapath. It accepts one operand pair per clock through a valid/ready handshake and multiplies in signed or unsigned mode, selected per transaction. A user tag travels with each operation. The pipeline stalls globally under output backpressure and can be flushed synchronously. It replaces the fixed unsigned, no-backpressure multiplier wherever a downstream consumer can stall.

## Interface

Parameters:
- N, 8, width of operand a (N ≥ 2)
- M, 8, width of operand b and number of pipeline stages (M ≥ 2)
- TW, 4, tag width (TW ≥ 1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-high
- flush  input  1  synchronous clear of all in-flight operations
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept this cycle
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned
- in_a  input  N  multiplicand
- in_b  input  M  multiplier
- in_tag  input  TW  user tag, returned unchanged with the result
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_result  output  N+M  product, same signedness as the request
- out_tag  output  TW  tag of the result

## Operation

- M register stages. Each stage holds a valid bit and the following fields:
  - N-bit magnitude of a
  - M-bit magnitude of b
  - negate flag
  - N+M-bit partial accumulator
  - tag
- Global enable: en = !out_valid || out_ready.
- in_ready = en && !flush. Acceptance = in_valid && in_ready.
- Stage 1 (loaded on acceptance):
  - When in_signed = 1, each operand is replaced by its absolute value.
  - negate flag = sign(a) XOR sign(b), only when in_signed = 1.
  - acc = |a| if bit 0 of |b| is set, else 0.
- Stage s (2..M): acc += |a| << (s-1) if bit s-1 of |b| is set.
- Stage M also applies the sign fix-up: the result is -acc when the negate flag is set, else acc.
- Stage M drives out_result, out_tag and out_valid directly.
- Magnitudes are treated as unsigned, so the most negative value is handled exactly. For example, |−2^(N-1)| fits in N bits.
- All N+M-bit arithmetic is performed with no overflow. Every legal product fits N+M bits in both modes.
- When en = 0, every stage holds, including bubbles. Bubbles are not compressed.
- When en = 1, each stage moves forward by one. Stage 1 loads the accepted input, or a bubble (valid = 0) if nothing is accepted.
- flush = 1 at an edge:
  - clears every stage valid bit, including the output stage;
  - overrides en and any pending input;
  - leaves data fields unchanged.
- in_signed = 0 with MSB-set operands: treated as plain unsigned values.

## Timing

- Reset values:
  - all valid bits 0, so out_valid = 0;
  - out_result = 0, out_tag = 0, all internal fields 0;
  - in_ready = 1 during and after reset, unless flush is asserted.
- Latency: an operation accepted at edge t appears with out_valid = 1 immediately after edge t+M-1. That is M clocks, counting the acceptance edge as the first.
- Throughput: one operation per clock while out_ready = 1.
- Results leave in acceptance order, with no loss and no duplication.
- When out_valid = 1 and out_ready = 0:
  - out_result and out_tag are held stable;
  - in_ready = 0 in the same cycle (combinational).
- Transfer occurs at an edge with out_valid && out_ready. The next result, if any, is presented in the following cycle.
- Flush and acceptance in the same cycle: flush wins, and the input is not accepted.
- Reset mid-operation: all in-flight results are lost. No out_valid pulse occurs after reset is released until a new operation completes.

## Test plan

1. N=M=8, out_ready=1. Inputs: unsigned a=25, b=10, tag=3. Expect out_valid after 8 clocks, result 250 (0x00FA), tag 3, one-cycle pulse.
2. Back-to-back unsigned stream: 25×10, 20×8, 15×7, 10×6, 5×3, 3×2. Expect results 250, 160, 105, 60, 15, 6 on six consecutive cycles, tags in order. Also 255×255 gives 65025 (0xFE01).
3. Signed cases: expect these results.
   - −128×−128 → 16384 (0x4000)
   - −3×5 → −15 (0xFFF1)
   - 127×−128 → −16256 (0xC080)
   - 0×−1 → 0
4. Stream of 6 operations with out_ready held low for 3 cycles after the first result. Expect:
   - out_result and out_tag held;
   - in_ready = 0 throughout the stall;
   - all 6 results delivered once, in order.
5. flush pulsed with 3 operations in flight and a valid input present. Expect:
   - none of the 3 flushed operations ever shows out_valid;
   - the flush-cycle input is not accepted;
   - the next operation, 7×9, returns 63 after M clocks.
6. rst asserted asynchronously, mid-cycle, with 4 operations in flight. Expect:
   - out_valid = 0 and out_result = 0 immediately, without waiting for an edge;
   - no stale results after release;
   - a subsequent 12×12 returns 144.

Source files
------------

// File: rtl/mult_pipeline_b.sv
// Pipelined shift-add multiplier: signed/unsigned per transaction, tagged,
// globally stalled by output backpressure, with synchronous flush.
module mult_pipeline_b #(
   parameter int unsigned N  = 8,
   parameter int unsigned M  = 8,
   parameter int unsigned TW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_signed,
   input  logic [N-1:0]    in_a,
   input  logic [M-1:0]    in_b,
   input  logic [TW-1:0]   in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N+M-1:0]  out_result,
   output logic [TW-1:0]   out_tag
);

   localparam int unsigned PW = N + M;

   logic          vld_q [M];
   logic [N-1:0]  a_q   [M];
   logic [M-1:0]  b_q   [M];
   logic          neg_q [M];
   logic [PW-1:0] acc_q [M];
   logic [TW-1:0] tag_q [M];
   logic [PW-1:0] acc_nxt [M];

   logic          en;
   logic          accept;
   logic [N-1:0]  a_mag;
   logic [M-1:0]  b_mag;
   logic          neg_in;

   assign en       = !vld_q[M-1] || out_ready;
   assign in_ready = en && !flush;
   assign accept   = in_valid && in_ready;

   // Magnitudes are kept unsigned so the most negative operand maps exactly.
   assign a_mag  = (in_signed && in_a[N-1]) ? N'(-in_a) : in_a;
   assign b_mag  = (in_signed && in_b[M-1]) ? M'(-in_b) : in_b;
   assign neg_in = in_signed && (in_a[N-1] ^ in_b[M-1]);
   assign acc_nxt[0] = b_mag[0] ? PW'(a_mag) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q[0] <= 1'b0;
         a_q[0]   <= '0;
         b_q[0]   <= '0;
         neg_q[0] <= 1'b0;
         acc_q[0] <= '0;
         tag_q[0] <= '0;
      end else if (flush) begin
         vld_q[0] <= 1'b0;
      end else if (en) begin
         vld_q[0] <= accept;
         if (accept) begin
            a_q[0]   <= a_mag;
            b_q[0]   <= b_mag;
            neg_q[0] <= neg_in;
            acc_q[0] <= acc_nxt[0];
            tag_q[0] <= in_tag;
         end
      end
   end

   for (genvar s = 1; s < M; s++) begin : g_stage
      logic [PW-1:0] addend;
      logic [PW-1:0] sum;

      assign addend = b_q[s-1][s] ? (PW'(a_q[s-1]) << s) : '0;
      assign sum    = acc_q[s-1] + addend;

      // The final stage folds in the sign fix-up.
      if (s == M - 1) begin : g_last
         assign acc_nxt[s] = neg_q[s-1] ? PW'(-sum) : sum;
      end else begin : g_mid
         assign acc_nxt[s] = sum;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q[s] <= 1'b0;
            a_q[s]   <= '0;
            b_q[s]   <= '0;
            neg_q[s] <= 1'b0;
            acc_q[s] <= '0;
            tag_q[s] <= '0;
         end else if (flush) begin
            vld_q[s] <= 1'b0;
         end else if (en) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) begin
               a_q[s]   <= a_q[s-1];
               b_q[s]   <= b_q[s-1];
               neg_q[s] <= neg_q[s-1];
               acc_q[s] <= acc_nxt[s];
               tag_q[s] <= tag_q[s-1];
            end
         end
      end
   end

   assign out_valid  = vld_q[M-1];
   assign out_result = acc_q[M-1];
   assign out_tag    = tag_q[M-1];

endmodule

// File: tb/tb_mult_pipeline_b.sv
// Self-checking bench for mult_pipeline_b: directed plan plus random traffic
// against an arithmetic reference model with an in-order scoreboard.
module tb_mult_pipeline_b;

   localparam int unsigned N  = 8;
   localparam int unsigned M  = 8;
   localparam int unsigned TW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic            in_signed;
   logic [N-1:0]    in_a;
   logic [M-1:0]    in_b;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [N+M-1:0]  out_result;
   logic [TW-1:0]   out_tag;

   typedef struct {
      logic [N+M-1:0] r;
      logic [TW-1:0]  t;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mult_pipeline_b #(.N(N), .M(M), .TW(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_signed  (in_signed),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [N+M-1:0] model(input logic s, input logic [N-1:0] a,
                                            input logic [M-1:0] b);
      int pa, pb;
      pa = s ? int'($signed(a)) : int'(a);
      pb = s ? int'($signed(b)) : int'(b);
      return (N+M)'(pa * pb);
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [TW-1:0] t);
      in_valid  = 1'b1;
      in_signed = s;
      in_a      = a;
      in_b      = b;
      in_tag    = t;
   endtask

   task automatic send(input logic s, input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic [TW-1:0] t);
      drive(s, a, b, t);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int k;
      k = 0;
      while (!out_valid && k < 100) begin
         tick();
         k++;
      end
      check(name, 32'(out_valid), 32'd1);
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (M + 4) tick();
      check(name, 32'(q.size()), 32'd0);
   endtask

   // Scoreboard: retire presented results, then record this cycle's acceptance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("extra_result", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("sb_result", 32'(out_result), 32'(e.r));
               check("sb_tag", 32'(out_tag), 32'(e.t));
            end
         end
         if (flush) begin
            q.delete();
         end else if (in_valid && in_ready) begin
            e.r = model(in_signed, in_a, in_b);
            e.t = in_tag;
            q.push_back(e);
         end
      end
   end

   initial begin
      logic [N+M-1:0] held_r;
      logic [TW-1:0]  held_t;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Latency and single-cycle pulse.
      send(1'b0, 8'd25, 8'd10, 4'd3);
      for (int k = 1; k < int'(M); k++) begin
         check("lat_idle", 32'(out_valid), 32'd0);
         if (k < int'(M) - 1) tick();
      end
      tick();
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_result", 32'(out_result), 32'd250);
      check("lat_tag", 32'(out_tag), 32'd3);
      tick();
      check("pulse_end", 32'(out_valid), 32'd0);

      // Back-to-back unsigned stream.
      drive(1'b0, 8'd25, 8'd10, 4'd1); tick();
      drive(1'b0, 8'd20, 8'd8,  4'd2); tick();
      drive(1'b0, 8'd15, 8'd7,  4'd3); tick();
      drive(1'b0, 8'd10, 8'd6,  4'd4); tick();
      drive(1'b0, 8'd5,  8'd3,  4'd5); tick();
      drive(1'b0, 8'd3,  8'd2,  4'd6); tick();
      drive(1'b0, 8'd255, 8'd255, 4'd7); tick();
      in_valid = 1'b0;
      wait_out("stream_wait");
      check("stream_first", 32'(out_result), 32'd250);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("stream_consec", 32'(out_valid), 32'd1);
      end
      check("stream_last", 32'(out_result), 32'hFE01);
      drain("stream_drain");

      // Signed corner cases.
      drive(1'b1, 8'h80, 8'h80, 4'd8);  tick();
      drive(1'b1, 8'hFD, 8'd5,  4'd9);  tick();
      drive(1'b1, 8'd127, 8'h80, 4'd10); tick();
      drive(1'b1, 8'd0, 8'hFF,  4'd11); tick();
      in_valid = 1'b0;
      wait_out("signed_wait");
      check("signed_m128sq", 32'(out_result), 32'h4000);
      tick(); check("signed_m3x5", 32'(out_result), 32'hFFF1);
      tick(); check("signed_127xm128", 32'(out_result), 32'hC080);
      tick(); check("signed_0xm1", 32'(out_result), 32'h0000);
      drain("signed_drain");

      // Backpressure stall.
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 8'(k + 2), 8'(k + 11), 4'(k + 1));
         tick();
      end
      in_valid = 1'b0;
      wait_out("stall_wait");
      out_ready = 1'b0;
      held_r = out_result;
      held_t = out_tag;
      check("stall_first", 32'(held_r), 32'(model(1'b0, 8'd2, 8'd11)));
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_result", 32'(out_result), 32'(held_r));
         check("stall_tag", 32'(out_tag), 32'(held_t));
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      drain("stall_drain");

      // Flush with three in flight and an input pending.
      send(1'b0, 8'd11, 8'd3, 4'd1);
      send(1'b0, 8'd12, 8'd3, 4'd2);
      send(1'b0, 8'd13, 8'd3, 4'd3);
      drive(1'b0, 8'd14, 8'd3, 4'd4);
      flush = 1'b1;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < int'(M) + 2; k++) begin
         check("flush_quiet", 32'(out_valid), 32'd0);
         tick();
      end
      send(1'b0, 8'd7, 8'd9, 4'd5);
      repeat (M - 1) tick();
      check("post_flush_valid", 32'(out_valid), 32'd1);
      check("post_flush_result", 32'(out_result), 32'd63);
      drain("flush_drain");

      // Asynchronous reset mid-cycle with four in flight.
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 8'(k + 30), 8'd7, 4'(k + 8));
         tick();
      end
      in_valid = 1'b0;
      tick(); tick(); tick();
      #1;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_result", 32'(out_result), 32'd0);
      q.delete();
      tick();
      #2;
      rst = 1'b0;
      for (int k = 0; k < int'(M) + 2; k++) begin
         tick();
         check("arst_quiet", 32'(out_valid), 32'd0);
      end
      send(1'b0, 8'd12, 8'd12, 4'd6);
      wait_out("arst_wait");
      check("arst_12x12", 32'(out_result), 32'd144);
      drain("arst_drain");

      // Random traffic with random backpressure.
      for (int k = 0; k < 200; k++) begin
         in_valid  = ($urandom % 4) != 0;
         in_signed = 1'($urandom);
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         in_tag    = 4'($urandom);
         out_ready = ($urandom % 4) != 0;
         tick();
      end
      drain("random_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
